alu_logic_issue: RTL and testbench

Issue stage directly upstream of the ALU logic unit: accepts decoded MIPS instruction fields plus register operands, selects operands, translates opcode/funct into the logic unit's 4-bit `ctrl` code, and presents {A, B, ctrl} from a registered output. Ready/valid on both sides with a 2-entry skid buffer, so a stall from the downstream ALU never drops or duplicates an operation and `in_ready` never depends combinationally on `out_ready`.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_logic_issue_if.sv | 31 +++
 rtl/skid_buffer.sv | 78 +++++++
 rtl/alu_logic_issue.sv | 79 +++++++
 tb/tb_alu_logic_issue.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and encodings for the logic-unit issue stage: opcode/funct values,
// logic-unit control codes and the payload carried through the skid buffer.
package alu_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned ImmWidth  = 16;
  localparam int unsigned CtrlWidth = 4;

  // Logic-unit control codes
  localparam logic [3:0] CTRL_AND    = 4'b1000;
  localparam logic [3:0] CTRL_OR     = 4'b1110;
  localparam logic [3:0] CTRL_XOR    = 4'b0110;
  localparam logic [3:0] CTRL_NOR    = 4'b0001;
  localparam logic [3:0] CTRL_PASS_A = 4'b1010;

  // MIPS opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // MIPS funct field values (R-type only)
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // How the A/B operands are formed for a decoded instruction
  typedef enum logic [1:0] {
    SelRegReg,
    SelRegImm,
    SelLui,
    SelNone
  } opnd_sel_e;

  typedef struct packed {
    logic [DataWidth-1:0] a;
    logic [DataWidth-1:0] b;
    logic [CtrlWidth-1:0] ctrl;
    logic                 illegal;
  } issue_t;

  localparam issue_t ISSUE_RESET = '{
    a:       '0,
    b:       '0,
    ctrl:    CTRL_PASS_A,
    illegal: 1'b0
  };

endpackage

// File: rtl/alu_logic_issue_if.sv
// Upstream decode fields plus downstream logic-unit operands, both sides ready/valid.
interface alu_logic_issue_if;

  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ctrl;
  logic        illegal;

  // Issue stage view
  modport slave (
    input  in_valid, opcode, funct, rs_data, rt_data, imm, out_ready,
    output in_ready, out_valid, A, B, ctrl, illegal
  );

  // Upstream + logic-unit view
  modport master (
    output in_valid, opcode, funct, rs_data, rt_data, imm, out_ready,
    input  in_ready, out_valid, A, B, ctrl, illegal
  );

endinterface

// File: rtl/skid_buffer.sv
// Generic 2-entry ready/valid buffer: output register plus one skid register.
// in_ready_o is a flop output, so it never depends combinationally on out_ready_i.
module skid_buffer #(
  parameter int unsigned       Width     = 32,
  parameter logic [Width-1:0]  ResetData = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q,  skid_data_d;
  logic             in_ready_q,   in_ready_d;

  logic accept;
  logic drain;

  assign accept = in_valid_i & in_ready_q;
  assign drain  = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (drain) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // in_ready_q implies the skid is empty, so accept never collides with a skid refill.
    if (accept) begin
      if (!out_valid_q || out_ready_i) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= ResetData;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/alu_logic_issue.sv
// Issue stage ahead of the ALU logic unit: decodes opcode/funct into a ctrl code,
// forms A/B operands and hands them to the logic unit through a skid buffer.
module alu_logic_issue
  import alu_pkg::*;
(
  input logic              clk,
  input logic              rst,
  alu_logic_issue_if.slave bus
);

  opnd_sel_e        sel;
  logic [3:0]       dec_ctrl;
  issue_t           dec;
  issue_t           out_q;

  // Opcode/funct -> operand selection and ctrl code
  always_comb begin
    sel      = SelNone;
    dec_ctrl = CTRL_PASS_A;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.funct)
          FN_AND: begin sel = SelRegReg; dec_ctrl = CTRL_AND; end
          FN_OR:  begin sel = SelRegReg; dec_ctrl = CTRL_OR;  end
          FN_XOR: begin sel = SelRegReg; dec_ctrl = CTRL_XOR; end
          FN_NOR: begin sel = SelRegReg; dec_ctrl = CTRL_NOR; end
          default: ;
        endcase
      end
      OP_ANDI: begin sel = SelRegImm; dec_ctrl = CTRL_AND;    end
      OP_ORI:  begin sel = SelRegImm; dec_ctrl = CTRL_OR;     end
      OP_XORI: begin sel = SelRegImm; dec_ctrl = CTRL_XOR;    end
      OP_LUI:  begin sel = SelLui;    dec_ctrl = CTRL_PASS_A; end
      default: ;
    endcase
  end

  // Operand formation; illegal ops leave A=B=0 with pass-A
  always_comb begin
    dec         = ISSUE_RESET;
    dec.ctrl    = dec_ctrl;
    dec.illegal = (sel == SelNone);
    unique case (sel)
      SelRegReg: begin
        dec.a = bus.rs_data;
        dec.b = bus.rt_data;
      end
      SelRegImm: begin
        dec.a = bus.rs_data;
        dec.b = {16'h0000, bus.imm};
      end
      SelLui: begin
        dec.a = {bus.imm, 16'h0000};
        dec.b = '0;
      end
      SelNone: ;
    endcase
  end

  skid_buffer #(
    .Width     ($bits(issue_t)),
    .ResetData (ISSUE_RESET)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (dec),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_q)
  );

  assign bus.A       = out_q.a;
  assign bus.B       = out_q.b;
  assign bus.ctrl    = out_q.ctrl;
  assign bus.illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_logic_issue.sv
// Directed + random bench for alu_logic_issue with an in-order scoreboard.
module tb_alu_logic_issue;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_logic_issue_if bus ();

  alu_logic_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [68:0] sb[$];
  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  int drained  = 0;

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode, packed as {A, B, ctrl, illegal}
  function automatic logic [68:0] model(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [15:0] im);
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic        il;
    a = 32'h0; b = 32'h0; c = 4'b1010; il = 1'b1;
    if (op == 6'b000000) begin
      if (fn == 6'b100100)      begin a = rs; b = rt; c = 4'b1000; il = 1'b0; end
      else if (fn == 6'b100101) begin a = rs; b = rt; c = 4'b1110; il = 1'b0; end
      else if (fn == 6'b100110) begin a = rs; b = rt; c = 4'b0110; il = 1'b0; end
      else if (fn == 6'b100111) begin a = rs; b = rt; c = 4'b0001; il = 1'b0; end
    end else if (op == 6'b001100) begin a = rs; b = {16'h0, im}; c = 4'b1000; il = 1'b0; end
    else if (op == 6'b001101)     begin a = rs; b = {16'h0, im}; c = 4'b1110; il = 1'b0; end
    else if (op == 6'b001110)     begin a = rs; b = {16'h0, im}; c = 4'b0110; il = 1'b0; end
    else if (op == 6'b001111)     begin a = {im, 16'h0}; c = 4'b1010; il = 1'b0; end
    return {a, b, c, il};
  endfunction

  function automatic logic [68:0] out_word();
    return {bus.A, bus.B, bus.ctrl, bus.illegal};
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im);
    bus.in_valid = v;
    bus.opcode   = op;
    bus.funct    = fn;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    bus.imm      = im;
  endtask

  // One clock: observe the handshakes that will fire on the coming edge, then step past it.
  task automatic cycle();
    logic [68:0] exp_w;
    @(negedge clk);
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        drained++;
        exp_w = 'x;
        if (sb.size() != 0) exp_w = sb.pop_front();
        check("sb_order", out_word(), exp_w);
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.opcode, bus.funct, bus.rs_data, bus.rt_data, bus.imm));
        accepted++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int target;
    int drained_snap;
    logic [5:0] op;
    logic [5:0] fn;

    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 6'h0, 6'h0, 32'h0, 32'h0, 16'h0);
    cycle();
    cycle();
    check("rst_out_valid", 69'(bus.out_valid), 69'(0));
    check("rst_fields", out_word(), {64'h0, 4'b1010, 1'b0});
    check("rst_in_ready", 69'(bus.in_ready), 69'(0));
    rst = 1'b0;
    cycle();
    check("in_ready_after_rst", 69'(bus.in_ready), 69'(1));

    // Single ORI with the consumer always ready
    bus.out_ready = 1'b1;
    drive(1'b1, 6'b001101, 6'b000000, 32'h1234_0000, 32'h5555_5555, 16'hABCD);
    cycle();
    bus.in_valid = 1'b0;
    check("ori_valid", 69'(bus.out_valid), 69'(1));
    check("ori_fields", out_word(), {32'h1234_0000, 32'h0000_ABCD, 4'b1110, 1'b0});
    cycle();
    check("ori_drained", 69'(bus.out_valid), 69'(0));

    // NOR, LUI, LW back to back
    drive(1'b1, 6'b000000, 6'b100111, 32'hF0F0_F0F0, 32'h0F0F_0000, 16'h1234);
    cycle();
    check("nor_fields", out_word(), {32'hF0F0_F0F0, 32'h0F0F_0000, 4'b0001, 1'b0});
    drive(1'b1, 6'b001111, 6'b100100, 32'hDEAD_BEEF, 32'h1111_2222, 16'hBEEF);
    cycle();
    check("lui_fields", out_word(), {32'hBEEF_0000, 32'h0, 4'b1010, 1'b0});
    drive(1'b1, 6'b100011, 6'b100100, 32'hCAFE_F00D, 32'h7777_7777, 16'h0040);
    cycle();
    check("lw_fields", out_word(), {64'h0, 4'b1010, 1'b1});
    bus.in_valid = 1'b0;
    cycle();
    check("lw_single_transfer", 69'(bus.out_valid), 69'(0));
    check("directed_count", 69'(drained), 69'(accepted));

    // Stall: AND held at output, OR in skid, XOR refused until release
    bus.out_ready = 1'b0;
    drive(1'b1, 6'b000000, 6'b100100, 32'hAAAA_5555, 32'h0FF0_0FF0, 16'h0);
    cycle();
    check("stall_ready_one", 69'(bus.in_ready), 69'(1));
    drive(1'b1, 6'b000000, 6'b100101, 32'h1111_0000, 32'h0000_2222, 16'h0);
    cycle();
    check("stall_ready_low", 69'(bus.in_ready), 69'(0));
    check("stall_hold_and", out_word(), {32'hAAAA_5555, 32'h0FF0_0FF0, 4'b1000, 1'b0});
    drive(1'b1, 6'b000000, 6'b100110, 32'h0000_0001, 32'h0000_0003, 16'h0);
    cycle();
    check("stall_ready_still_low", 69'(bus.in_ready), 69'(0));
    check("stall_hold_stable", out_word(), {32'hAAAA_5555, 32'h0FF0_0FF0, 4'b1000, 1'b0});
    bus.out_ready = 1'b1;
    cycle();
    check("release_or", out_word(), {32'h1111_0000, 32'h0000_2222, 4'b1110, 1'b0});
    check("release_ready", 69'(bus.in_ready), 69'(1));
    cycle();
    check("release_xor", out_word(), {32'h0000_0001, 32'h0000_0003, 4'b0110, 1'b0});
    bus.in_valid = 1'b0;
    cycle();
    check("stall_sb_empty", 69'(sb.size()), 69'(0));
    check("stall_out_idle", 69'(bus.out_valid), 69'(0));

    // Random traffic with random back-pressure
    target = accepted + 100;
    cyc = 0;
    while (accepted < target && cyc < 3000) begin
      case ($urandom_range(0, 7))
        0, 1, 2: op = 6'b000000;
        3:       op = 6'b001100;
        4:       op = 6'b001101;
        5:       op = 6'b001110;
        6:       op = 6'b001111;
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 5) < 4) fn = 6'b100100 + 6'($urandom_range(0, 3));
      else fn = 6'($urandom);
      drive($urandom_range(0, 4) != 0, op, fn, $urandom, $urandom, 16'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      cyc++;
    end
    check("rand_accept_budget", 69'(accepted >= target), 69'(1));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    check("rand_sb_empty", 69'(sb.size()), 69'(0));
    check("rand_out_idle", 69'(bus.out_valid), 69'(0));

    // Reset with both slots full discards them
    bus.out_ready = 1'b0;
    drive(1'b1, 6'b001100, 6'b000000, 32'h1357_9BDF, 32'h0, 16'h00FF);
    cycle();
    drive(1'b1, 6'b001110, 6'b000000, 32'h2468_ACE0, 32'h0, 16'hFF00);
    cycle();
    check("occ2_ready_low", 69'(bus.in_ready), 69'(0));
    rst = 1'b1;
    drive(1'b1, 6'b000000, 6'b100101, 32'h1, 32'h2, 16'h0);
    cycle();
    sb.delete();
    drained_snap = drained;
    check("midrst_out_valid", 69'(bus.out_valid), 69'(0));
    check("midrst_fields", out_word(), {64'h0, 4'b1010, 1'b0});
    check("midrst_in_ready", 69'(bus.in_ready), 69'(0));
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    check("post_rst_in_ready", 69'(bus.in_ready), 69'(1));
    repeat (3) cycle();
    check("post_rst_no_output", 69'(drained - drained_snap), 69'(0));
    check("post_rst_out_valid", 69'(bus.out_valid), 69'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
